// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked out by the
// device, ACK sampling and timeouts. Drives the pads through open-drain enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MAX_AB = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int MAX_T  = (MAX_AB > INHIBIT_CYCLES) ? MAX_AB : INHIBIT_CYCLES;
  localparam int TW     = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, WAIT_DEV, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t          state;
  logic            clk_s1, clk_s2, clk_prev;
  logic            dat_s1, dat_s2;
  logic            fall;
  logic [7:0]      shift_reg;
  logic            parity;
  logic [3:0]      bit_idx;
  logic [TW-1:0]   timer;
  logic            start_expired, xfer_expired, ack_missing, fail;

  // Frame bit presented after fall number k+1: data LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic p, input logic [3:0] k);
    if (k < 4'd8)       return d[k[2:0]];
    else if (k == 4'd8) return p;
    else                return 1'b1;
  endfunction

  // Two-flop synchronisers; reset to the idle-bus level so no false fall appears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk) begin
    if (state == IDLE && tx_valid) begin
      shift_reg <= tx_data;
      parity    <= ~^tx_data;
    end
  end

  assign start_expired = (state == WAIT_DEV) && !fall && (timer == START_LAST);
  assign xfer_expired  = (state == SEND || state == ACK || state == WAIT_IDLE) &&
                         (timer == XFER_LAST);
  assign ack_missing   = (state == ACK) && fall && dat_s2;
  assign fail          = start_expired | xfer_expired | ack_missing;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      bit_idx    <= 4'd0;
      timer      <= '0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (fail) begin
        error      <= 1'b1;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        tx_ready   <= 1'b1;
        busy       <= 1'b0;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (tx_valid) begin
              timer      <= '0;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (timer == INH_LAST) begin
              ps2_dat_oe <= 1'b1;
              state      <= RTS;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          RTS: begin
            ps2_clk_oe <= 1'b0;
            timer      <= '0;
            state      <= WAIT_DEV;
          end
          WAIT_DEV: begin
            // The first device fall already shifts out data bit 0.
            if (fall) begin
              ps2_dat_oe <= ~shift_reg[0];
              bit_idx    <= 4'd1;
              timer      <= '0;
              state      <= SEND;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          SEND: begin
            timer <= timer + TW'(1);
            if (fall) begin
              ps2_dat_oe <= ~frame_bit(shift_reg, parity, bit_idx);
              bit_idx    <= bit_idx + 4'd1;
              if (bit_idx == 4'd9) state <= ACK;
            end
          end
          ACK: begin
            timer <= timer + TW'(1);
            if (fall) begin
              ps2_dat_oe <= 1'b0;
              state      <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            timer <= timer + TW'(1);
            if (clk_s2 && dat_s2) begin
              done     <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
          default: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on the open-drain pads, a table of
// frames, and hand-written timeout / reset / back-to-back sequences.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int ST   = 4000;
  localparam int XT   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  // Open-drain pads with pull-ups: either side may pull low.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  int checks = 0;
  int errors = 0;

  // Observations written only by the monitor
  int         cyc = 0;
  int         ready_viol = 0;
  int         both_cnt = 0;
  int         obs_n = 0;
  logic       obs_done [16];
  int         obs_cyc  [16];
  logic [2:0] obs_snap [16];
  int         inh_run = 0;
  int         inh_len = 0;
  int         drop_cyc = 0;
  logic       prev_clk_oe = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        if (tx_ready == busy) ready_viol++;
        if (done && error) both_cnt++;
        if ((done || error) && obs_n < 16) begin
          obs_done[obs_n] = done;
          obs_cyc[obs_n]  = cyc;
          obs_snap[obs_n] = {ps2_clk_oe, ps2_dat_oe, tx_ready};
          obs_n++;
        end
        if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
        else begin
          if (ps2_clk_oe && ps2_dat_oe && inh_run != 0) inh_len = inh_run;
          inh_run = 0;
        end
        if (prev_clk_oe && !ps2_clk_oe) drop_cyc = cyc;
      end
      prev_clk_oe = ps2_clk_oe;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected outcome per accepted byte (1 = done, 0 = error)
  logic exp_q[$];
  int   rd = 0;

  task automatic wait_accept(output int acc_cyc, output bit ok);
    ok = 0;
    acc_cyc = 0;
    for (int i = 0; i < 3 * XT; i++) begin
      if (tx_ready && tx_valid) begin
        acc_cyc = cyc + 1;
        @(posedge clk); #2;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_result(input string name, input int bound, output int ev_cyc);
    logic e;
    ev_cyc = 0;
    for (int i = 0; i < bound; i++) begin
      if (obs_n > rd) break;
      @(negedge clk);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
    if (obs_n > rd) begin
      check({name, "_outcome"}, 32'(obs_done[rd]), 32'(e));
      check({name, "_idle_lines"}, 32'(obs_snap[rd]), 32'h1);
      ev_cyc = obs_cyc[rd];
      rd++;
    end else begin
      check({name, "_result_timeout"}, 32'h0, 32'h1);
    end
  endtask

  // Device model: samples start bit, then data on each rising edge; optional ACK.
  task automatic dev_frame(input int pulses, input bit ack, output logic [10:0] bits,
                           output int fall_cyc, output bit ok);
    bits = '0;
    fall_cyc = 0;
    ok = 0;
    for (int i = 0; i < INH + 100; i++) begin
      @(negedge clk);
      if (ps2_dat_oe && !ps2_clk_oe) begin
        ok = 1;
        break;
      end
    end
    if (!ok) return;
    repeat (10) @(negedge clk);
    bits[0] = ps2_dat_in;
    for (int i = 1; i <= pulses; i++) begin
      dev_clk = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = ps2_dat_in;
      if (i == 10 && ack) dev_dat = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_dat = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         pulses;
    bit         ack;
    bit         exp_done;
  } vec_t;

  vec_t vecs[4];

  task automatic run_frame(input string name, input vec_t v);
    int acc, fc, ec;
    bit ok;
    logic [10:0] bits;
    tx_data  = v.data;
    tx_valid = 1'b1;
    wait_accept(acc, ok);
    check({name, "_accept"}, 32'(ok), 32'h1);
    tx_valid = 1'b0;
    exp_q.push_back(v.exp_done);
    dev_frame(v.pulses, v.ack, bits, fc, ok);
    check({name, "_dev_start"}, 32'(ok), 32'h1);
    check({name, "_frame_bits"}, 32'(bits), 32'({1'b1, v.par, v.data, 1'b0}));
    check({name, "_inhibit_len"}, 32'(inh_len), 32'(INH));
    wait_result(name, XT + 200, ec);
    if (!v.exp_done) check({name, "_err_latency"}, 32'(ec - fc), 32'h3);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int acc1, acc2, ec, fc, saved;
    bit ok;
    logic [10:0] bits;

    vecs[0] = '{data: 8'hF4, par: 1'b0, pulses: 11, ack: 1'b1, exp_done: 1'b1};
    vecs[1] = '{data: 8'hED, par: 1'b1, pulses: 11, ack: 1'b1, exp_done: 1'b1};
    vecs[2] = '{data: 8'hFF, par: 1'b1, pulses: 11, ack: 1'b0, exp_done: 1'b0};
    vecs[3] = '{data: 8'h00, par: 1'b1, pulses: 11, ack: 1'b1, exp_done: 1'b1};

    reset = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({tx_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe}), 32'b100000);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Device never clocks: start timeout
    tx_data = 8'h01;
    tx_valid = 1'b1;
    wait_accept(acc1, ok);
    check("timeout_accept", 32'(ok), 32'h1);
    tx_valid = 1'b0;
    exp_q.push_back(1'b0);
    wait_result("timeout", INH + ST + 200, ec);
    check("timeout_latency", 32'(ec - drop_cyc), 32'(ST));
    repeat (5) @(negedge clk);

    // Reset during SEND after five falls
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    wait_accept(acc1, ok);
    check("rst_accept", 32'(ok), 32'h1);
    tx_valid = 1'b0;
    dev_frame(5, 1'b0, bits, fc, ok);
    check("rst_dev_start", 32'(ok), 32'h1);
    check("rst_busy_mid_send", 32'(busy), 32'h1);
    reset = 1'b0;
    @(posedge clk); #2;
    check("rst_mid_outputs", 32'({tx_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe}), 32'b100000);
    @(negedge clk);
    reset = 1'b1;
    saved = rd;
    repeat (50) @(negedge clk);
    check("rst_no_pulse", 32'(obs_n), 32'(saved));
    run_frame("after_rst", vecs[0]);

    // tx_valid held: 0xF4 then 0xED back to back
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    wait_accept(acc1, ok);
    check("b2b_accept1", 32'(ok), 32'h1);
    exp_q.push_back(1'b1);
    tx_data = 8'hED;
    dev_frame(11, 1'b1, bits, fc, ok);
    check("b2b_bits1", 32'(bits), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    wait_result("b2b1", XT + 200, ec);
    wait_accept(acc2, ok);
    check("b2b_accept2", 32'(ok), 32'h1);
    check("b2b_accept_gap", 32'(acc2 - ec), 32'h1);
    tx_valid = 1'b0;
    exp_q.push_back(1'b1);
    dev_frame(11, 1'b1, bits, fc, ok);
    check("b2b_bits2", 32'(bits), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    wait_result("b2b2", XT + 200, ec);
    repeat (20) @(negedge clk);

    check("no_extra_pulses", 32'(obs_n), 32'(rd));
    check("done_error_overlap", 32'(both_cnt), 32'h0);
    check("ready_busy_consistent", 32'(ready_viol), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the outbound counterpart of the keyboard receive path and sends command bytes to the keyboard, for example 0xED set-LEDs, 0xF4 enable and 0xFF reset. It sits beside the keyboard driver in the top level and shares the PS2_CLK and PS2_DAT pads through open-drain enables. A game-side FSM hands it one byte at a time; it reports success (device ACK) or error (no ACK or timeout).

Parameters:
INHIBIT_CYCLES, 6000, cycles ps2_clk is held low for request-to-send (120 us at 50 MHz).
START_TIMEOUT, 750000, max cycles from clock release to the first device falling edge (15 ms).
XFER_TIMEOUT, 100000, max cycles from the first falling edge to the ACK sample (2 ms).

Ports:
clk  in  1  system clock (CLOCK_50 at top level).
reset  in  1  synchronous, active-low reset.
tx_data  in  8  byte to send.
tx_valid  in  1  request to send tx_data.
tx_ready  out  1  high only in IDLE; a byte is accepted on tx_valid & tx_ready.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse: byte sent and device ACK seen.
error  out  1  one-cycle pulse: timeout or missing ACK.
ps2_clk_in  in  1  raw PS2_CLK pad value (asynchronous).
ps2_dat_in  in  1  raw PS2_DAT pad value (asynchronous).
ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (pad pull-up).
ps2_dat_oe  out  1  1 = drive PS2_DAT low; 0 = release.

Behaviour:
Reset is synchronous, active-low. While reset=0 on a clk edge:
- State goes to IDLE; bit counter and timers clear.
- Reset values: tx_ready=1, busy=0, done=0, error=0, ps2_clk_oe=0, ps2_dat_oe=0.
- Reset asserted mid-transfer releases both lines on that same edge; the frame is abandoned with no done or error pulse.

Input sync and edge detect:
- ps2_clk_in and ps2_dat_in pass through 2-flop synchronisers.
- fall = previous synced clk 1 and current synced clk 0.
- Pad-to-fall latency is 3 clk cycles.

Accept:
- On tx_valid & tx_ready, latch tx_data into shift_reg.
- Latch parity = ~^tx_data (odd parity).
- Go to INHIBIT. tx_valid in any other state is ignored.

States:
- IDLE: both oe=0. Accept as above.
- INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: one cycle with ps2_clk_oe=1 and ps2_dat_oe=1 (start bit), then go to WAIT_DEV with ps2_clk_oe=0 and ps2_dat_oe held at 1.
- WAIT_DEV: wait for the first fall, then go to SEND with bit index k=0.
  - If START_TIMEOUT cycles elapse first: error.
- SEND: on each fall, present the next value on the data line:
  - k=0..7: tx_data[k] (LSB first).
  - k=8: parity.
  - k=9: stop bit 1.
  - Drive rule: ps2_dat_oe = ~bit.
  - After presenting the stop bit, go to ACK.
- ACK: on the next fall, sample synced dat.
  - 0: go to WAIT_IDLE as success.
  - 1: error.
- WAIT_IDLE: both oe=0. When synced clk=1 and synced dat=1, pulse done and go to IDLE.
- Timeout during transfer: XFER_TIMEOUT counts from entering SEND. Expiry in SEND, ACK or WAIT_IDLE gives error.
- Error handling: error pulses for one cycle, both oe go to 0 on the same edge, and the state goes to IDLE.
- done and error never assert together; each pulses at most once per accepted byte.

Boundary cases:
- tx_valid held high across done: the next byte is accepted on the cycle after returning to IDLE (tx_ready=1).
- Device clocks during INHIBIT (edges seen while ps2_clk_oe=1): ignored.
- A glitch fall in WAIT_IDLE: ignored.

Test Plan:
- Send 0xF4 with a device model clocking at 12.5 kHz and ACKing.
  - Lines sampled by the model at rising edges: start 0, then 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - done pulses once; error stays 0.
- Send 0xED, device ACKs.
  - Data bits 1,0,1,1,0,1,1,1, parity 1.
  - ps2_clk_oe is high for exactly 6000 cycles before ps2_dat_oe rises.
- Send 0x01, device never clocks.
  - error pulses 750000 cycles after ps2_clk_oe drops; both oe=0; tx_ready=1; done never asserts.
- Send 0xFF, device clocks 11 edges but leaves dat high at ACK.
  - Parity bit 1 observed.
  - error pulses 3 cycles after the 11th fall; both oe released.
- Drive reset low during SEND at k=4.
  - Next edge: ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, no done or error.
  - A fresh 0xF4 then completes normally.
- tx_valid held high with 0xF4 then 0xED.
  - Two back-to-back frames, two done pulses.
  - tx_ready=0 throughout each frame.
